// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - playback controller: play/pause, skip, auto-advance, end of playlist
module song_sequencer #(
  parameter int SONG_BITS    = 2,
  parameter bit AUTO_ADVANCE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next_button,
  input  logic                 song_done,
  output logic                 play,
  output logic                 reset_player,
  output logic [SONG_BITS-1:0] song,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    ADVANCE = 2'd2,
    REWIND  = 2'd3
  } state_e;

  localparam logic [SONG_BITS-1:0] LAST_SONG = '1;
  localparam logic [SONG_BITS-1:0] ONE       = SONG_BITS'(1);

  state_e               state_q, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic                 resume_q, resume_d;
  logic [SONG_BITS-1:0] song_inc;

  assign song_inc = song_q + ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= PAUSED;
      song_q   <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      resume_q <= resume_d;
    end
  end

  // Priority next_button > song_done > play_button; lower pulses are dropped.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    unique case (state_q)
      PAUSED: begin
        if (next_button) begin
          state_d  = ADVANCE;
          song_d   = song_inc;
          resume_d = 1'b0;
        end else if (play_button) begin
          state_d = PLAYING;
        end
      end
      PLAYING: begin
        if (next_button) begin
          state_d  = ADVANCE;
          song_d   = song_inc;
          resume_d = 1'b1;
        end else if (song_done) begin
          if (AUTO_ADVANCE) begin
            state_d = ADVANCE;
            if (song_q != LAST_SONG) begin
              song_d   = song_inc;
              resume_d = 1'b1;
            end else begin
              song_d   = '0;
              resume_d = 1'b0;
            end
          end else begin
            state_d  = REWIND;
            resume_d = 1'b0;
          end
        end else if (play_button) begin
          state_d = PAUSED;
        end
      end
      ADVANCE: state_d = resume_q ? PLAYING : PAUSED;
      REWIND:  state_d = PAUSED;
      default: state_d = PAUSED;
    endcase
  end

  always_comb begin
    play         = (state_q == PLAYING);
    reset_player = (state_q == ADVANCE) || (state_q == REWIND);
    state_dbg    = state_q;
  end

  assign song = song_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - scoreboard bench for song_sequencer, auto-advance and rewind variants
module tb_song_sequencer;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] r;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, pb, nb, sd;
  logic       a_play, a_rp, r_play, r_rp;
  logic [1:0] a_song, a_st, r_song, r_st;

  int   checks = 0;
  int   failures = 0;
  int   m_st[2];
  int   m_song[2];
  int   m_res[2];
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  song_sequencer #(.SONG_BITS(2), .AUTO_ADVANCE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .play_button(pb), .next_button(nb), .song_done(sd),
    .play(a_play), .reset_player(a_rp), .song(a_song), .state_dbg(a_st)
  );

  song_sequencer #(.SONG_BITS(2), .AUTO_ADVANCE(1'b0)) dut_r (
    .clk(clk), .reset(reset), .play_button(pb), .next_button(nb), .song_done(sd),
    .play(r_play), .reset_player(r_rp), .song(r_song), .state_dbg(r_st)
  );

  function automatic logic [5:0] pack(int i);
    logic p, rp;
    p  = (m_st[i] == 1);
    rp = (m_st[i] >= 2);
    return {p, rp, 2'(m_song[i]), 2'(m_st[i])};
  endfunction

  task automatic model_step(int i, logic r, logic p, logic n, logic d);
    bit autoadv;
    autoadv = (i == 0);
    if (!r) begin
      m_st[i] = 0; m_song[i] = 0; m_res[i] = 0;
    end else begin
      case (m_st[i])
        0: if (n) begin
             m_st[i] = 2; m_song[i] = (m_song[i] + 1) % 4; m_res[i] = 0;
           end else if (p) m_st[i] = 1;
        1: if (n) begin
             m_st[i] = 2; m_song[i] = (m_song[i] + 1) % 4; m_res[i] = 1;
           end else if (d) begin
             if (autoadv && m_song[i] != 3) begin
               m_st[i] = 2; m_song[i] = m_song[i] + 1; m_res[i] = 1;
             end else if (autoadv) begin
               m_st[i] = 2; m_song[i] = 0; m_res[i] = 0;
             end else begin
               m_st[i] = 3; m_res[i] = 0;
             end
           end else if (p) m_st[i] = 0;
        2: m_st[i] = m_res[i] ? 1 : 0;
        default: m_st[i] = 0;
      endcase
    end
  endtask

  task automatic cycle(logic [3:0] s);
    reset = s[3]; pb = s[2]; nb = s[1]; sd = s[0];
    model_step(0, s[3], s[2], s[1], s[0]);
    model_step(1, s[3], s[2], s[1], s[0]);
    sb.push_back('{a: pack(0), r: pack(1)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] st[$];
    st.push_back({1'b0, 3'($urandom)});
    st.push_back({1'b0, 3'($urandom)});
    for (int i = 0; i < 10; i++) st.push_back(4'b1000);
    foreach (st[k]) begin
      cycle(st[k]);
      e = sb.pop_front();
      checks++;
      if ({a_play, a_rp, a_song, a_st} !== e.a) begin
        failures++;
        $display("FAIL reset_a cyc%0d got=%b exp=%b", k, {a_play, a_rp, a_song, a_st}, e.a);
      end
      checks++;
      if ({r_play, r_rp, r_song, r_st} !== e.r) begin
        failures++;
        $display("FAIL reset_r cyc%0d got=%b exp=%b", k, {r_play, r_rp, r_song, r_st}, e.r);
      end
    end
    checks++;
    if ({a_play, a_rp, a_song, a_st} !== 6'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=000000", {a_play, a_rp, a_song, a_st});
    end
  endtask

  task automatic test_play_pause();
    logic [3:0] st[$];
    st = '{4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1000};
    foreach (st[k]) begin
      cycle(st[k]);
      e = sb.pop_front();
      checks++;
      if ({a_play, a_rp, a_song, a_st} !== e.a) begin
        failures++;
        $display("FAIL play_pause_a cyc%0d got=%b exp=%b", k, {a_play, a_rp, a_song, a_st}, e.a);
      end
      checks++;
      if (a_rp !== 1'b0) begin
        failures++;
        $display("FAIL play_pause_no_rp cyc%0d got=%b exp=0", k, a_rp);
      end
    end
  endtask

  task automatic test_skip();
    logic [3:0] st[$];
    st = '{4'b1010, 4'b1000, 4'b1100, 4'b1010, 4'b1000};
    foreach (st[k]) begin
      cycle(st[k]);
      e = sb.pop_front();
      checks++;
      if ({a_play, a_rp, a_song, a_st} !== e.a || {r_play, r_rp, r_song, r_st} !== e.r) begin
        failures++;
        $display("FAIL skip cyc%0d got=%b/%b exp=%b/%b", k, {a_play, a_rp, a_song, a_st},
                 {r_play, r_rp, r_song, r_st}, e.a, e.r);
      end
    end
    checks++;
    if ({a_play, a_song} !== 3'b1_10) begin
      failures++;
      $display("FAIL skip_end got=%b exp=110", {a_play, a_song});
    end
  endtask

  task automatic test_last_song();
    logic [3:0] st[$];
    st = '{4'b1010, 4'b1000, 4'b1001, 4'b1000};
    foreach (st[k]) begin
      cycle(st[k]);
      e = sb.pop_front();
      checks++;
      if ({a_play, a_rp, a_song, a_st} !== e.a || {r_play, r_rp, r_song, r_st} !== e.r) begin
        failures++;
        $display("FAIL last_song cyc%0d got=%b/%b exp=%b/%b", k, {a_play, a_rp, a_song, a_st},
                 {r_play, r_rp, r_song, r_st}, e.a, e.r);
      end
    end
    checks++;
    if ({a_play, a_song, r_song} !== 5'b0_00_11) begin
      failures++;
      $display("FAIL last_song_end got=%b exp=00011", {a_play, a_song, r_song});
    end
  endtask

  task automatic test_priority();
    logic [3:0] st[$];
    st = '{4'b0000, 4'b1100, 4'b1111, 4'b1000};
    foreach (st[k]) begin
      cycle(st[k]);
      e = sb.pop_front();
      checks++;
      if ({a_play, a_rp, a_song, a_st} !== e.a || {r_play, r_rp, r_song, r_st} !== e.r) begin
        failures++;
        $display("FAIL priority cyc%0d got=%b/%b exp=%b/%b", k, {a_play, a_rp, a_song, a_st},
                 {r_play, r_rp, r_song, r_st}, e.a, e.r);
      end
    end
    checks++;
    if ({a_play, a_song, r_play, r_song} !== 6'b1_01_1_01) begin
      failures++;
      $display("FAIL priority_end got=%b exp=101101", {a_play, a_song, r_play, r_song});
    end
  endtask

  task automatic test_rewind();
    logic [3:0] st[$];
    st = '{4'b1010, 4'b1000, 4'b1001, 4'b1000, 4'b0000, 4'b1010, 4'b0000, 4'b1000};
    foreach (st[k]) begin
      cycle(st[k]);
      e = sb.pop_front();
      checks++;
      if ({r_play, r_rp, r_song, r_st} !== e.r) begin
        failures++;
        $display("FAIL rewind_r cyc%0d got=%b exp=%b", k, {r_play, r_rp, r_song, r_st}, e.r);
      end
      checks++;
      if ({a_play, a_rp, a_song, a_st} !== e.a) begin
        failures++;
        $display("FAIL rewind_a cyc%0d got=%b exp=%b", k, {a_play, a_rp, a_song, a_st}, e.a);
      end
    end
    checks++;
    if ({r_rp, r_song, r_st} !== 5'b0) begin
      failures++;
      $display("FAIL reset_in_advance got=%b exp=00000", {r_rp, r_song, r_st});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s;
    for (int k = 0; k < 300; k++) begin
      s[3] = ($urandom_range(0, 40) != 0);
      s[2] = ($urandom_range(0, 3) == 0);
      s[1] = ($urandom_range(0, 4) == 0);
      s[0] = ($urandom_range(0, 3) == 0);
      cycle(s);
      e = sb.pop_front();
      checks++;
      if ({a_play, a_rp, a_song, a_st} !== e.a || {r_play, r_rp, r_song, r_st} !== e.r) begin
        failures++;
        $display("FAIL random cyc%0d in=%b got=%b/%b exp=%b/%b", k, s, {a_play, a_rp, a_song, a_st},
                 {r_play, r_rp, r_song, r_st}, e.a, e.r);
      end
    end
  endtask

  initial begin
    reset = 1'b0; pb = 1'b0; nb = 1'b0; sd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_song[i] = 0; m_res[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_play_pause();
    test_skip();
    test_last_song();
    test_priority();
    test_rewind();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Top-level playback controller for the music player.
- Turns debounced user button pulses and the song reader's end-of-song pulse into three signals: the play level, a one-cycle player-restart pulse, and the current song index.
- Sits between the button conditioning logic and the song reader / note player chain. It sequences start, pause, skip, auto-advance and end-of-playlist.

Parameters:
- SONG_BITS, 2, width of the song index; playlist length = 2**SONG_BITS.
- AUTO_ADVANCE, 1, 1: song_done moves to the next song; 0: song_done rewinds the current song and pauses.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising clk edge resets the block
- play_button  input  1  one-cycle pulse, toggles play/pause
- next_button  input  1  one-cycle pulse, skip to next song
- song_done  input  1  one-cycle pulse from song reader: last note of current song finished
- play  output  1  level to song reader: 1 = advance through notes
- reset_player  output  1  one-cycle pulse: song reader and note player restart at start of song
- song  output  SONG_BITS  current song index, drives song reader base address
- state_dbg  output  2  current state encoding, for LEDs/debug

Behaviour:
- Four-state Moore FSM, 2-bit state register. Encoding: PAUSED=0, PLAYING=1, ADVANCE=2, REWIND=3.
- Registers: state, song, and a 1-bit resume flag.
- play, reset_player and state_dbg decode from the state register only. No combinational path exists from inputs to outputs.
- Reset (reset==0 at edge):
  - state=PAUSED, song=0, resume=0.
  - Outputs on the following cycle: play=0, reset_player=0, state_dbg=0.
  - Reset has priority over every input and takes effect mid-song, mid-ADVANCE or mid-REWIND.
- Output decode:
  - PAUSED: play=0, reset_player=0.
  - PLAYING: play=1, reset_player=0.
  - ADVANCE and REWIND: play=0, reset_player=1.
- Input priority when several pulses coincide: next_button > song_done > play_button. Lower-priority pulses in the same cycle are dropped, not queued.
- PAUSED transitions:
  - next_button -> ADVANCE; song<=song+1 (mod 2**SONG_BITS); resume<=0.
  - else play_button -> PLAYING.
  - else stay. song_done is ignored in PAUSED.
- PLAYING transitions:
  - next_button -> ADVANCE; song<=song+1 (wraps); resume<=1.
  - else song_done with AUTO_ADVANCE=1 and song != 2**SONG_BITS-1 -> ADVANCE; song<=song+1; resume<=1.
  - else song_done with AUTO_ADVANCE=1 and song == last -> ADVANCE; song<=0; resume<=0. The playlist ends paused at song 0.
  - else song_done with AUTO_ADVANCE=0 -> REWIND; song unchanged; resume<=0.
  - else play_button -> PAUSED.
  - else stay.
- ADVANCE: exactly one cycle, all inputs ignored. Next state is PLAYING if resume==1, else PAUSED.
- REWIND: exactly one cycle, all inputs ignored. Next state is PAUSED.
- Song index timing:
  - song updates on the same edge that enters ADVANCE.
  - The new index is therefore valid for the entire reset_player=1 cycle, so the reader restarts at the new song's base.
  - song changes only on entry to ADVANCE, or on reset.
- Latency:
  - Button/done pulse sampled at edge N: play/reset_player reflect the new state from edge N onward (visible in cycle N+1).
  - Skip while playing: play drops for exactly one cycle (the ADVANCE cycle), then returns to 1.
- Wrap: next_button at song=2**SONG_BITS-1 gives song=0. resume follows the PLAYING/PAUSED rule; there is no end-of-playlist stop on manual skip.
- No latching of input pulses across cycles. Pulses arriving during ADVANCE/REWIND are lost by design; upstream pulses are at least one cycle apart.

Test Plan:
1. reset=0 for 2 cycles with random buttons, then reset=1 -> play=0, reset_player=0, song=0, state_dbg=0. Hold 10 idle cycles -> unchanged.
2. play_button pulse -> play=1 next cycle. Second play_button 5 cycles later -> play=0. song stays 0 and reset_player never pulses.
3. Playing at song=1, next_button pulse -> next cycle: song=2, reset_player=1, play=0. Following cycle: reset_player=0, play=1.
4. SONG_BITS=2, AUTO_ADVANCE=1, playing at song=3, song_done pulse -> song=0 with reset_player=1 for one cycle, then PAUSED with play=0.
5. Playing at song=0, next_button, song_done and play_button in the same cycle -> single ADVANCE to song=1, then PLAYING. No double increment, no pause.
6. AUTO_ADVANCE=0, playing at song=2, song_done -> REWIND: reset_player=1, song=2, then PAUSED. reset=0 asserted during ADVANCE cycle (paused, next_button at song=1) -> song=0, PAUSED, reset_player=0 next cycle.
